// File: rtl/mem_access_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_ctrl_if
//  Description : Bundle of every non-clock signal of mem_access_ctrl: the
//                write-request, read-request and read-response handshake
//                channels, the single-port-per-direction RAM control bus
//                and the accepted-request counters.
//
//  Port summary (direction as seen by the controller, modport slave):
//    wr_req_valid/ready/addr/data  in/out/in/in    write request channel
//    rd_req_valid/ready/addr       in/out/in       read request channel
//    rd_rsp_valid/ready/data       out/in/out      read response channel
//    memory_enable, write          out             RAM write strobes
//    operation_enable, read        out             RAM read strobes
//    write_address, read_address   out             RAM addresses
//    data_in                       out             RAM write data
//    data_out                      in              RAM read data (1 clk late)
//    wr_count, rd_count            out             accepted-request counters
//
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_ctrl_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 10
);
    // Write request channel
    logic              wr_req_valid;
    logic              wr_req_ready;
    logic [ADDR_W-1:0] wr_req_addr;
    logic [DATA_W-1:0] wr_req_data;

    // Read request channel
    logic              rd_req_valid;
    logic              rd_req_ready;
    logic [ADDR_W-1:0] rd_req_addr;

    // Read response channel
    logic              rd_rsp_valid;
    logic              rd_rsp_ready;
    logic [DATA_W-1:0] rd_rsp_data;

    // RAM side
    logic              memory_enable;
    logic              write;
    logic              operation_enable;
    logic              read;
    logic [ADDR_W-1:0] write_address;
    logic [ADDR_W-1:0] read_address;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;

    // Statistics
    logic [15:0]       wr_count;
    logic [15:0]       rd_count;

    // The controller itself
    modport slave (
        input  wr_req_valid, wr_req_addr, wr_req_data,
        output wr_req_ready,
        input  rd_req_valid, rd_req_addr,
        output rd_req_ready,
        output rd_rsp_valid, rd_rsp_data,
        input  rd_rsp_ready,
        output memory_enable, write, operation_enable, read,
        output write_address, read_address, data_in,
        input  data_out,
        output wr_count, rd_count
    );

    // The environment: requesters plus the RAM
    modport master (
        output wr_req_valid, wr_req_addr, wr_req_data,
        input  wr_req_ready,
        output rd_req_valid, rd_req_addr,
        input  rd_req_ready,
        input  rd_rsp_valid, rd_rsp_data,
        output rd_rsp_ready,
        input  memory_enable, write, operation_enable, read,
        input  write_address, read_address, data_in,
        output data_out,
        input  wr_count, rd_count
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_ctrl
//  Description : Front end for a RAM with one registered read port and one
//                write port. Writes pass straight through with no response.
//                Reads are issued to the RAM, the data returned one clock
//                later is captured in a 2-entry response FIFO and handed back
//                in request order on a valid/ready response channel.
//                Read acceptance is credit-based so the FIFO never overflows
//                and a read to the address being written in the same cycle
//                is held off by one cycle so it observes the new data.
//
//  Parameters  : DATA_W  RAM data width (must match the interface instance)
//                ADDR_W  RAM address width (must match the interface instance)
//
//  Ports       : clk    rising-edge clock
//                rst_n  synchronous active-low reset
//                bus    mem_access_ctrl_if.slave - request/response channels,
//                       RAM control bus and the two request counters
//
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 10
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    mem_access_ctrl_if.slave   bus
);

    localparam logic [1:0]  c_FIFO_DEPTH = 2'd2;
    localparam logic [15:0] c_CNT_MAX    = 16'hFFFF;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] fifo_q [0:1];
    logic [DATA_W-1:0] fifo_d [0:1];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q,  count_d;
    logic              inflight_q, inflight_d;
    logic [15:0]       wr_count_q, wr_count_d;
    logic [15:0]       rd_count_q, rd_count_d;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] w_wr_addr;
    logic [ADDR_W-1:0] w_rd_addr;
    logic              w_wr_hs;
    logic              w_hazard;
    logic              w_rsp_valid;
    logic              w_pop;
    logic              w_push;
    logic [2:0]        w_occupancy;
    logic              w_credit;
    logic              w_rd_ready;
    logic              w_rd_hs;

    assign w_wr_addr   = bus.wr_req_addr;
    assign w_rd_addr   = bus.rd_req_addr;

    // The write channel is always open outside reset.
    assign w_wr_hs     = bus.wr_req_valid & rst_n;

    // Same-address write and read in one cycle: the write goes first and the
    // read waits a cycle, so it sees the freshly written word.
    assign w_hazard    = w_wr_hs & (w_wr_addr == w_rd_addr);

    assign w_rsp_valid = (count_q != 2'd0);
    assign w_pop       = w_rsp_valid & bus.rd_rsp_ready;

    // A read issued last cycle has its RAM data on data_out this cycle.
    assign w_push      = inflight_q;

    // Slots already promised = stored entries + the read still in the RAM,
    // minus the entry leaving this cycle. w_pop implies count_q >= 1, so the
    // subtraction cannot underflow.
    assign w_occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, w_pop};
    assign w_credit    = (w_occupancy < {1'b0, c_FIFO_DEPTH});

    assign w_rd_ready  = rst_n & ~w_hazard & w_credit;
    assign w_rd_hs     = bus.rd_req_valid & w_rd_ready;

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.wr_req_ready     = rst_n;
    assign bus.rd_req_ready     = w_rd_ready;

    assign bus.memory_enable    = w_wr_hs;
    assign bus.write            = w_wr_hs;
    assign bus.write_address    = w_wr_addr;
    assign bus.data_in          = bus.wr_req_data;

    assign bus.operation_enable = w_rd_hs;
    assign bus.read             = w_rd_hs;
    assign bus.read_address     = w_rd_addr;

    assign bus.rd_rsp_valid     = w_rsp_valid;
    assign bus.rd_rsp_data      = fifo_q[rd_ptr_q];

    assign bus.wr_count         = wr_count_q;
    assign bus.rd_count         = rd_count_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        inflight_d = w_rd_hs;
        wr_count_d = wr_count_q;
        rd_count_d = rd_count_q;

        if (w_push) begin
            fifo_d[wr_ptr_q] = bus.data_out;
            wr_ptr_d         = ~wr_ptr_q;
        end

        if (w_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        // Simultaneous push and pop leaves the occupancy unchanged.
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        if (w_wr_hs && (wr_count_q != c_CNT_MAX)) begin
            wr_count_d = wr_count_q + 16'd1;
        end

        if (w_rd_hs && (rd_count_q != c_CNT_MAX)) begin
            rd_count_d = rd_count_q + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // Clearing inflight on reset drops any read still in the RAM pipeline;
    // the FIFO storage is cleared too so rd_rsp_data reads zero until the
    // first response is captured.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fifo_q     <= '{default: '0};
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            inflight_q <= 1'b0;
            wr_count_q <= 16'd0;
            rd_count_q <= 16'd0;
        end else begin
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            wr_count_q <= wr_count_d;
            rd_count_q <= rd_count_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_ctrl
//  Description : Directed bench for mem_access_ctrl with a RAM model and a
//                queue-based reference model of the response path.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

    localparam int DW = 64;
    localparam int AW = 10;

    logic clk;
    logic rst_n;

    int tests = 0;
    int fails = 0;

    mem_access_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    mem_access_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] pat(input int i);
        return 64'hA5A5_0000_0000_0000 | 64'(i);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // RAM: write at the edge, read data registered one clock later
    // ------------------------------------------------------------------
    logic [63:0] ram [1024];
    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = pat(i);
        ram[9] = 64'h55;
        bus.data_out <= '0;
        forever begin
            @(posedge clk);
            if (bus.read)  bus.data_out <= ram[bus.read_address];
            if (bus.write) ram[bus.write_address] = bus.data_in;
        end
    end

    // ------------------------------------------------------------------
    // Reference model: shadow memory, queue of reads in the RAM pipeline,
    // queue of buffered responses. Checked every cycle after first reset.
    // ------------------------------------------------------------------
    logic [63:0] shadow [1024];
    logic [63:0] pend [$];
    logic [63:0] rspq [$];
    int          m_wcnt, m_rcnt;
    bit          m_init  = 1'b0;
    bit          m_ever  = 1'b0;

    initial begin
        bit e_wr_hs, e_haz, e_pop, e_rd_rdy, e_rd_hs;
        int occ;
        for (int i = 0; i < 1024; i++) shadow[i] = pat(i);
        shadow[9] = 64'h55;
        m_wcnt = 0;
        m_rcnt = 0;
        forever begin
            @(negedge clk);
            e_wr_hs  = rst_n && bus.wr_req_valid;
            e_haz    = e_wr_hs && (bus.wr_req_addr == bus.rd_req_addr);
            e_pop    = (rspq.size() != 0) && bus.rd_rsp_ready;
            occ      = rspq.size() + pend.size() - (e_pop ? 1 : 0);
            e_rd_rdy = rst_n && !e_haz && (occ < 2);
            e_rd_hs  = bus.rd_req_valid && e_rd_rdy;
            if (m_init) begin
                chk("wr_req_ready", bus.wr_req_ready, rst_n);
                chk("rd_req_ready", bus.rd_req_ready, e_rd_rdy);
                chk("write", bus.write, e_wr_hs);
                chk("memory_enable", bus.memory_enable, e_wr_hs);
                chk("read", bus.read, e_rd_hs);
                chk("operation_enable", bus.operation_enable, e_rd_hs);
                if (e_wr_hs) begin
                    chk("write_address", bus.write_address, bus.wr_req_addr);
                    chk("data_in", bus.data_in, bus.wr_req_data);
                end
                if (e_rd_hs) chk("read_address", bus.read_address, bus.rd_req_addr);
                chk("rd_rsp_valid", bus.rd_rsp_valid, rspq.size() != 0);
                if (rspq.size() != 0)  chk("rd_rsp_data", bus.rd_rsp_data, rspq[0]);
                else if (!m_ever)      chk("rd_rsp_data_zero", bus.rd_rsp_data, 64'h0);
                chk("wr_count", bus.wr_count, 64'(m_wcnt));
                chk("rd_count", bus.rd_count, 64'(m_rcnt));
            end
            @(posedge clk);
            if (!rst_n) begin
                pend.delete();
                rspq.delete();
                m_wcnt = 0;
                m_rcnt = 0;
                m_ever = 1'b0;
                m_init = 1'b1;
            end else begin
                if (e_pop) void'(rspq.pop_front());
                if (pend.size() != 0) begin
                    rspq.push_back(pend.pop_front());
                    m_ever = 1'b1;
                end
                if (e_rd_hs) begin
                    pend.push_back(shadow[bus.rd_req_addr]);
                    if (m_rcnt < 16'hFFFF) m_rcnt++;
                end
                if (e_wr_hs) begin
                    shadow[bus.wr_req_addr] = bus.wr_req_data;
                    if (m_wcnt < 16'hFFFF) m_wcnt++;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus with literal expectations
    // ------------------------------------------------------------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    initial begin
        rst_n             = 1'b0;
        bus.wr_req_valid  = 1'b0;
        bus.wr_req_addr   = '0;
        bus.wr_req_data   = '0;
        bus.rd_req_valid  = 1'b0;
        bus.rd_req_addr   = '0;
        bus.rd_rsp_ready  = 1'b1;

        repeat (3) cyc();
        neg();
        chk("reset_wr_ready", bus.wr_req_ready, 0);
        chk("reset_rd_ready", bus.rd_req_ready, 0);
        chk("reset_wr_count", bus.wr_count, 0);

        cyc(); rst_n = 1'b1;
        neg();
        chk("post_reset_rsp_valid", bus.rd_rsp_valid, 0);
        chk("post_reset_rsp_data", bus.rd_rsp_data, 0);
        chk("post_reset_wr_ready", bus.wr_req_ready, 1);

        // Write then read addr 5
        cyc(); bus.wr_req_valid = 1'b1; bus.wr_req_addr = 10'd5; bus.wr_req_data = 64'h0123_4567_89AB_CDEF;
        neg(); chk("wr5_write", bus.write, 1);
        cyc(); bus.wr_req_valid = 1'b0; bus.rd_req_valid = 1'b1; bus.rd_req_addr = 10'd5;
        neg(); chk("rd5_ready", bus.rd_req_ready, 1);
        cyc(); bus.rd_req_valid = 1'b0;
        neg(); chk("rd5_t1_valid", bus.rd_rsp_valid, 0);
        cyc();
        neg();
        chk("rd5_t2_valid", bus.rd_rsp_valid, 1);
        chk("rd5_t2_data", bus.rd_rsp_data, 64'h0123_4567_89AB_CDEF);
        chk("rd5_rd_count", bus.rd_count, 1);
        chk("rd5_wr_count", bus.wr_count, 1);

        // Same-cycle write and read of addr 9
        cyc(); bus.wr_req_valid = 1'b1; bus.wr_req_addr = 10'd9; bus.wr_req_data = 64'hAA;
               bus.rd_req_valid = 1'b1; bus.rd_req_addr = 10'd9;
        neg(); chk("haz_rd_ready", bus.rd_req_ready, 0); chk("haz_write", bus.write, 1);
        cyc(); bus.wr_req_valid = 1'b0;
        neg(); chk("haz_retry_ready", bus.rd_req_ready, 1);
        cyc(); bus.rd_req_valid = 1'b0;
        cyc();
        neg(); chk("haz_rsp_valid", bus.rd_rsp_valid, 1); chk("haz_rsp_data", bus.rd_rsp_data, 64'hAA);

        // Back-pressure: reads 1,2,3 with rd_rsp_ready low
        cyc(); bus.rd_rsp_ready = 1'b0; bus.rd_req_valid = 1'b1; bus.rd_req_addr = 10'd1;
        neg(); chk("bp_rd1_ready", bus.rd_req_ready, 1);
        cyc(); bus.rd_req_addr = 10'd2;
        neg(); chk("bp_rd2_ready", bus.rd_req_ready, 1);
        cyc(); bus.rd_req_addr = 10'd3;
        neg(); chk("bp_rd3_stall", bus.rd_req_ready, 0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            neg();
            chk("bp_full_stall", bus.rd_req_ready, 0);
            chk("bp_hold_data", bus.rd_rsp_data, 64'hA5A5_0000_0000_0001);
        end
        cyc(); bus.rd_rsp_ready = 1'b1;
        neg();
        chk("bp_rsp1", bus.rd_rsp_data, 64'hA5A5_0000_0000_0001);
        chk("bp_rd3_accept", bus.rd_req_ready, 1);
        cyc(); bus.rd_req_valid = 1'b0;
        neg(); chk("bp_rsp2", bus.rd_rsp_data, 64'hA5A5_0000_0000_0002);
        cyc();
        neg(); chk("bp_rsp3_valid", bus.rd_rsp_valid, 1); chk("bp_rsp3", bus.rd_rsp_data, 64'hA5A5_0000_0000_0003);
        cyc();
        neg();
        chk("bp_drained", bus.rd_rsp_valid, 0);
        chk("bp_rd_count", bus.rd_count, 5);
        chk("bp_wr_count", bus.wr_count, 2);

        // Four back-to-back reads, addrs 0..3
        for (int j = 0; j < 6; j++) begin
            cyc();
            bus.rd_req_valid = (j < 4);
            bus.rd_req_addr  = 10'(j);
            neg();
            if (j < 4) chk("b2b_ready", bus.rd_req_ready, 1);
            if (j >= 2) begin
                chk("b2b_valid", bus.rd_rsp_valid, 1);
                chk("b2b_data", bus.rd_rsp_data, 64'hA5A5_0000_0000_0000 + 64'(j - 2));
            end
        end
        cyc();
        neg(); chk("b2b_done", bus.rd_rsp_valid, 0);

        // Reset while a read is in flight
        cyc(); bus.rd_req_valid = 1'b1; bus.rd_req_addr = 10'd7;
        neg(); chk("rstif_issue", bus.rd_req_ready, 1);
        cyc(); rst_n = 1'b0;
               bus.wr_req_valid = 1'b1; bus.wr_req_addr = 10'd20; bus.wr_req_data = 64'h1;
               bus.rd_req_addr = 10'd21;
        neg();
        chk("rstif_wr_ready", bus.wr_req_ready, 0);
        chk("rstif_rd_ready", bus.rd_req_ready, 0);
        chk("rstif_memory_enable", bus.memory_enable, 0);
        chk("rstif_write", bus.write, 0);
        chk("rstif_operation_enable", bus.operation_enable, 0);
        chk("rstif_read", bus.read, 0);
        cyc();
        cyc(); rst_n = 1'b1; bus.wr_req_valid = 1'b0; bus.rd_req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            neg(); chk("rstif_no_rsp", bus.rd_rsp_valid, 0);
            cyc();
        end
        neg();
        chk("rstif_wr_count", bus.wr_count, 0);
        chk("rstif_rd_count", bus.rd_count, 0);

        // rd_count saturation: stream to 0xFFFE, then three more reads
        for (int i = 0; i < 65534; i++) begin
            cyc();
            bus.rd_req_valid = 1'b1;
            bus.rd_req_addr  = 10'(i % 1024);
        end
        cyc(); bus.rd_req_valid = 1'b0;
        neg(); chk("sat_fffe", bus.rd_count, 16'hFFFE);
        for (int i = 0; i < 3; i++) begin
            cyc(); bus.rd_req_valid = 1'b1; bus.rd_req_addr = 10'(100 + i);
        end
        cyc(); bus.rd_req_valid = 1'b0;
        neg(); chk("sat_ffff", bus.rd_count, 16'hFFFF);
        repeat (4) cyc();
        neg(); chk("sat_hold", bus.rd_count, 16'hFFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64: data width, matching the RAM data_in/data_out width.
REQ-002 The block SHALL have parameter ADDR_W, default 10: address width, matching the 1024-entry RAM.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 Ports wr_req_valid (input, 1), wr_req_ready (output, 1), wr_req_addr (input, ADDR_W), wr_req_data (input, DATA_W): write request channel.
REQ-006 Ports rd_req_valid (input, 1), rd_req_ready (output, 1), rd_req_addr (input, ADDR_W): read request channel.
REQ-007 Ports rd_rsp_valid (output, 1), rd_rsp_ready (input, 1), rd_rsp_data (output, DATA_W): read response channel.
REQ-008 RAM-side outputs: memory_enable, write, operation_enable and read (1 bit each), write_address and read_address (ADDR_W each), data_in (DATA_W).
REQ-009 RAM-side input: data_out (DATA_W); the RAM registers it one clock after a read is issued.
REQ-010 Ports wr_count and rd_count, output, 16 each: accepted-request counters.

Function
REQ-011 A channel transfer SHALL occur only in a cycle where both valid and ready are 1.
REQ-012 RAM controls SHALL be combinational from the handshakes:
- write = memory_enable = wr_req_valid & wr_req_ready, with write_address = wr_req_addr and data_in = wr_req_data.
- read = operation_enable = rd_req_valid & rd_req_ready, with read_address = rd_req_addr.
REQ-013 wr_req_ready SHALL be 1 whenever rst_n = 1; a write SHALL have no response.
REQ-014 The block SHALL hold a 2-entry response FIFO and a 1-bit inflight flag; inflight is set on the edge ending an issue cycle and cleared one cycle later.
REQ-015 Credit rule: rd_req_ready = rst_n & ~hazard & (fifo_count + inflight + pop_this_cycle_adjust < 2), where pop_this_cycle_adjust = -1 if rd_rsp_valid & rd_rsp_ready, else 0.
REQ-016 Hazard: hazard = 1 when write handshake conditions hold and wr_req_addr == rd_req_addr.
- The read SHALL stall that cycle; the write proceeds.
- Consequence: a read issued the next cycle returns the new data.
REQ-017 In the cycle after an issue (inflight = 1), the block SHALL push data_out into the FIFO at the edge ending that cycle.
REQ-018 Latency: read accepted in cycle t -> rd_rsp_valid = 1 in cycle t+2 if the FIFO was empty, with rd_rsp_data equal to the memory contents at issue.
REQ-019 rd_rsp_data SHALL be the FIFO head, held stable while rd_rsp_valid & ~rd_rsp_ready; responses SHALL be returned in request order.
REQ-020 FIFO push and pop in the same cycle SHALL leave the count unchanged; FIFO pointers wrap modulo 2.
REQ-021 The FIFO SHALL never overflow; a full FIFO (count 2) or count 1 with inflight and no pop SHALL force rd_req_ready = 0.
REQ-022 Back-to-back reads, one per cycle, SHALL sustain full throughput while rd_rsp_ready = 1.
REQ-023 wr_count SHALL increment on each write handshake and rd_count on each read handshake; both saturate at 16'hFFFF without wrap.

Reset
REQ-024 While rst_n = 0 at a rising edge, the block SHALL empty the FIFO and clear inflight, wr_count and rd_count to 0.
REQ-025 While rst_n = 0, wr_req_ready, rd_req_ready, memory_enable, write, operation_enable and read SHALL all be 0.
REQ-026 rd_rsp_valid SHALL be 0 in the first cycle after reset.
REQ-027 Reset during an inflight read SHALL discard that read; no response SHALL appear after reset release.
REQ-028 rd_rsp_data SHALL be 0 after reset until the first push.

Verification
REQ-029 Write 0x0123_4567_89AB_CDEF to addr 5, then read addr 5 with rd_rsp_ready = 1 -> rd_rsp_valid exactly 2 cycles after the read handshake, data 0x0123_4567_89AB_CDEF; rd_count = 1, wr_count = 1.
REQ-030 Same cycle: write 0xAA to addr 9 and read addr 9 (addr 9 holding 0x55) -> rd_req_ready = 0 that cycle; read accepted next cycle; response 0xAA.
REQ-031 With rd_rsp_ready = 0, issue reads to addrs 1, 2, 3 each cycle -> two accepted, rd_req_ready = 0 thereafter. Then rd_rsp_ready = 1 -> data for addrs 1 and 2 in order, then the addr 3 read is accepted.
REQ-032 Four consecutive reads, addrs 0..3, with rd_rsp_ready = 1 -> four responses on four consecutive cycles starting 2 cycles after the first handshake.
REQ-033 Assert rst_n = 0 in the cycle after a read issue -> no rd_rsp_valid after release; wr_count = rd_count = 0; RAM controls 0 during reset.
REQ-034 Force rd_count to 16'hFFFE, then perform 3 reads -> rd_count = 16'hFFFF.
